// File: rtl/fir_mac_filter.sv
// rtl/fir_mac_filter.sv - 16-tap symmetric FIR filter with a single time-shared MAC
//
// Ports:
//   clk       : system clock, rising-edge active
//   rst       : asynchronous active-high reset
//   din       : 12-bit offset-binary input sample (2048 = zero)
//   in_valid  : din carries a sample this cycle
//   in_ready  : filter can accept a sample this cycle
//   dout      : 28-bit signed full-precision filter output, held between results
//   out_valid : one-cycle pulse marking dout as new
//   overrun   : one-cycle pulse when an offered sample is dropped
module fir_mac_filter (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] din,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [27:0] dout,
    output logic        out_valid,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic signed [11:0] r_x [16];
    logic        [2:0]  r_k;
    logic signed [27:0] r_acc;
    logic signed [27:0] r_dout;
    logic               r_run;

    logic               w_accept;
    logic signed [11:0] w_coef;
    logic signed [11:0] w_xa;
    logic signed [11:0] w_xb;
    logic signed [12:0] w_pre;
    logic signed [24:0] w_prod;
    logic signed [27:0] w_acc_next;

    // Only h[0..7] are stored; the symmetric partner of tap k is tap 15-k.
    function automatic logic signed [11:0] coef_lookup(input logic [2:0] k);
        case (k)
            3'd0:    coef_lookup = -12'sd12;
            3'd1:    coef_lookup = -12'sd25;
            3'd2:    coef_lookup = 12'sd0;
            3'd3:    coef_lookup = 12'sd110;
            3'd4:    coef_lookup = 12'sd280;
            3'd5:    coef_lookup = 12'sd470;
            3'd6:    coef_lookup = 12'sd640;
            default: coef_lookup = 12'sd720;
        endcase
    endfunction

    // r_run holds in_ready low while in reset and until the first clock edge after it.
    assign in_ready  = r_run && (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign overrun   = in_valid && !in_ready && !rst;
    assign out_valid = (r_state == S_DONE);
    assign dout      = r_dout;

    // {1, ~k} equals 15-k for k in 0..7.
    assign w_coef     = coef_lookup(r_k);
    assign w_xa       = r_x[{1'b0, r_k}];
    assign w_xb       = r_x[{1'b1, ~r_k}];
    assign w_pre      = {w_xa[11], w_xa} + {w_xb[11], w_xb};
    assign w_prod     = w_pre * w_coef;
    assign w_acc_next = r_acc + {{3{w_prod[24]}}, w_prod};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_MAC;
            S_MAC:  if (r_k == 3'd7) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_k     <= 3'd0;
            r_acc   <= 28'sd0;
            r_dout  <= 28'sd0;
            for (int i = 0; i < 16; i++) begin
                r_x[i] <= 12'sd0;
            end
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if (w_accept) begin
                // Inverting the MSB turns offset-binary into two's complement.
                r_x[0] <= din ^ 12'h800;
                for (int i = 1; i < 16; i++) begin
                    r_x[i] <= r_x[i-1];
                end
                r_acc <= 28'sd0;
                r_k   <= 3'd0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + 3'd1;
                // The final sum is captured as the FSM enters DONE so dout is
                // already new while out_valid is high.
                if (r_k == 3'd7) begin
                    r_dout <= w_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb/tb_fir_mac_filter.sv - directed self-checking bench for fir_mac_filter
module tb_fir_mac_filter;

    logic        clk;
    logic        rst;
    logic [11:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] dout;
    logic        out_valid;
    logic        overrun;

    int n_checks;
    int n_errors;

    int imp_exp [16] = '{-12, -25, 0, 110, 280, 470, 640, 720,
                         720, 640, 470, 280, 110, 0, -25, -12};

    fir_mac_filter dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        din      = 12'd2049;
        @(negedge clk);
        check_val("rst_in_ready", int'(in_ready), 0);
        check_val("rst_dout", int'($signed(dout)), 0);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_overrun", int'(overrun), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        din      = 12'd2048;
        @(negedge clk);
        check_val("ready_after_rst", int'(in_ready), 1);
    endtask

    // Offer one sample, wait for its result, then idle for gap cycles.
    task automatic send(input logic [11:0] v, input int gap, output int res);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_wait", int'(in_ready), 1);
        din      = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", n, 9);
        res = int'($signed(dout));
        repeat (gap) @(negedge clk);
        if (gap > 0) check_val("dout_hold", int'($signed(dout)), res);
    endtask

    task automatic run_impulse(input string tag, input int gap);
        int r;
        for (int i = 0; i < 16; i++) begin
            send((i == 0) ? 12'd2049 : 12'd2048, gap, r);
            check_val($sformatf("%s_%0d", tag, i), r, imp_exp[i]);
        end
    endtask

    initial begin
        int r;
        int last_acc;
        int last_ov;
        int n_acc;
        int n_ov;
        int ovr_cnt;
        int seen_ov;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 12'd2048;
        @(negedge clk);

        do_reset();
        run_impulse("impulse", 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            send(12'd2148, 0, r);
            if (i == 0) check_val("dc_first", r, -1200);
            if (i >= 15) check_val($sformatf("dc_%0d", i), r, 436600);
        end

        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(12'd0, 0, r);
            if (i == 0) check_val("min_first", r, 24576);
            if (i >= 15) check_val($sformatf("min_%0d", i), r, -8941568);
        end

        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(12'd4095, 0, r);
            if (i >= 15) check_val($sformatf("max_%0d", i), r, 8937202);
        end

        do_reset();
        din      = 12'd2148;
        in_valid = 1'b1;
        last_acc = 0;
        last_ov  = 0;
        n_acc    = 0;
        n_ov     = 0;
        ovr_cnt  = 0;
        for (int i = 0; i < 45; i++) begin
            if (in_ready) begin
                check_val("ovr_on_accept", int'(overrun), 0);
                if (n_acc > 0) begin
                    check_val("accept_spacing", i - last_acc, 10);
                    check_val("overrun_count", ovr_cnt, 9);
                end
                last_acc = i;
                n_acc++;
                ovr_cnt = 0;
            end else if (overrun) begin
                ovr_cnt++;
            end
            if (out_valid) begin
                if (n_ov > 0) check_val("out_valid_spacing", i - last_ov, 10);
                last_ov = i;
                n_ov++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("accept_total", n_acc, 5);
        check_val("out_valid_total", n_ov, 4);
        repeat (12) @(negedge clk);

        do_reset();
        din      = 12'd2049;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        din      = 12'd2048;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_out_valid", int'(out_valid), 0);
        check_val("abort_dout", int'($signed(dout)), 0);
        check_val("abort_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        seen_ov = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov++;
        end
        check_val("abort_no_out_valid", seen_ov, 0);
        check_val("abort_dout_after", int'($signed(dout)), 0);
        run_impulse("post_abort", 0);

        do_reset();
        run_impulse("gap", 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
